halt_dump_monitor: RTL and testbench

- Synthesizable on-chip monitor beside the ad1xx CPU core, watching the fetch stream for a terminal jump-to-self loop (program end).
- On detection, sequences a read of a parametrised RAM window and streams each word out over a valid/ready channel (UART/debug/bench sink).
- Parametrised successor of the fixed "instruction stopped changing, dump RAM[0..11]" bench check: generic widths, threshold, window, handshake and re-arm.

---
 rtl/hdm_pkg.sv | 17 +
 rtl/hdm_stable_detect.sv | 56 +++++
 rtl/halt_dump_monitor.sv | 160 ++++++++++++++++
 tb/tb_halt_dump_monitor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdm_pkg.sv
// Shared types and helpers for halt_dump_monitor.
package hdm_pkg;

    typedef enum logic [2:0] {
        WATCH = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } hdm_state_e;

    // Counter must be able to hold the threshold value itself.
    function automatic int stable_cnt_w(input int stable_cycles);
        return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/hdm_stable_detect.sv
// Jump-to-self detector: counts consecutive identical {pc,inst} fetches and
// emits a one-cycle halt_pulse on the fetch that reaches STABLE_CYCLES.
module hdm_stable_detect
    import hdm_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 8,
    parameter int STABLE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              inst_valid,
    input  logic [DATA_W-1:0] inst,
    input  logic [ADDR_W-1:0] pc,
    output logic              halt_pulse
);

    localparam int CNT_W = stable_cnt_w(STABLE_CYCLES);

    logic              prev_valid;
    logic [ADDR_W-1:0] prev_pc;
    logic [DATA_W-1:0] prev_inst;
    logic [CNT_W-1:0]  stable_cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              match;

    assign match      = prev_valid && (pc == prev_pc) && (inst == prev_inst);
    assign cnt_inc    = stable_cnt + CNT_W'(1);
    assign halt_pulse = en && inst_valid && match && (cnt_inc == CNT_W'(STABLE_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
            prev_pc    <= '0;
            prev_inst  <= '0;
            stable_cnt <= '0;
        end else if (clr) begin
            prev_valid <= 1'b0;
            stable_cnt <= '0;
        end else if (en && inst_valid) begin
            if (!match) begin
                prev_valid <= 1'b1;
                prev_pc    <= pc;
                prev_inst  <= inst;
                stable_cnt <= '0;
            end else if (halt_pulse) begin
                stable_cnt <= '0;
            end else begin
                stable_cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/halt_dump_monitor.sv
// Program-end monitor: detects a jump-to-self fetch loop, then streams a RAM
// window out over valid/ready. Optional watchdog trigger: HDM_WATCHDOG_EN.
module halt_dump_monitor
    import hdm_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 8,
    parameter int STABLE_CYCLES = 16,
    parameter int DUMP_BASE     = 0,
    parameter int DUMP_COUNT    = 12,
    parameter int WDOG_CYCLES   = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    input  logic [DATA_W-1:0] inst,
    input  logic [ADDR_W-1:0] pc,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              halted,
    output logic              done,
    output logic              timeout,
    input  logic              rearm
);

    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("halt_dump_monitor: STABLE_CYCLES must be >= 1");
    end
    if (DUMP_COUNT < 1) begin : g_bad_count
        $error("halt_dump_monitor: DUMP_COUNT must be >= 1");
    end
    if ((longint'(DUMP_BASE) + longint'(DUMP_COUNT)) > (longint'(1) << ADDR_W)) begin : g_bad_window
        $error("halt_dump_monitor: dump window exceeds address space");
    end
    if (WDOG_CYCLES < 1) begin : g_bad_wdog
        $error("halt_dump_monitor: WDOG_CYCLES must be >= 1");
    end

    localparam int                IDX_W    = (DUMP_COUNT > 1) ? $clog2(DUMP_COUNT) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DUMP_COUNT - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(DUMP_BASE);

    hdm_state_e        state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] rd_addr;
    logic              halt_pulse;
    logic              wdog_fire;
    logic              rearm_ok;

    assign rd_addr   = BASE + ADDR_W'(idx);
    assign rearm_ok  = (state == DONE) && rearm;
    assign mem_rd_en = (state == READ);
    assign mem_addr  = mem_rd_en ? rd_addr : '0;

    hdm_stable_detect #(
        .DATA_W        (DATA_W),
        .ADDR_W        (ADDR_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_detect (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (state == WATCH),
        .clr        (rearm_ok),
        .inst_valid (inst_valid),
        .inst       (inst),
        .pc         (pc),
        .halt_pulse (halt_pulse)
    );

`ifdef HDM_WATCHDOG_EN
    localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    logic [WDOG_W-1:0] wdog_cnt;
    logic              timeout_q;

    assign wdog_fire = (state == WATCH) && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
    assign timeout   = timeout_q;

    // A real halt on the same cycle as the watchdog takes precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (rearm_ok) begin
            wdog_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (state == WATCH) begin
            if (!wdog_fire)
                wdog_cnt <= wdog_cnt + WDOG_W'(1);
            if (wdog_fire && !halt_pulse)
                timeout_q <= 1'b1;
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= WATCH;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WATCH:   if (halt_pulse || wdog_fire) state_nxt = READ;
            READ:    state_nxt = WAIT;
            WAIT:    state_nxt = OUT;
            OUT:     if (dump_ready) state_nxt = dump_last ? DONE : READ;
            DONE:    if (rearm) state_nxt = WATCH;
            default: state_nxt = WATCH;
        endcase
    end

    // RAM data is valid in WAIT, one cycle after the READ strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_last  <= 1'b0;
            halted     <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (state)
                WATCH: if (halt_pulse) halted <= 1'b1;
                WAIT: begin
                    dump_data  <= mem_rd_data;
                    dump_addr  <= rd_addr;
                    dump_last  <= (idx == LAST_IDX);
                    dump_valid <= 1'b1;
                end
                OUT: if (dump_ready) begin
                    dump_valid <= 1'b0;
                    if (dump_last)
                        done <= 1'b1;
                    else
                        idx <= idx + IDX_W'(1);
                end
                DONE: if (rearm) begin
                    halted <= 1'b0;
                    done   <= 1'b0;
                    idx    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_halt_dump_monitor.sv
// Directed bench for halt_dump_monitor: table-driven fetch vectors plus
// hand-written dump, backpressure, re-arm and mid-dump reset sequences.
module tb_halt_dump_monitor;

    localparam int DW     = 32;
    localparam int AW     = 8;
    localparam int NWORDS = 12;
    localparam int BASE   = 0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          inst_valid = 1'b0;
    logic [DW-1:0] inst = '0;
    logic [AW-1:0] pc = '0;
    logic          rearm = 1'b0;
    logic          dump_ready = 1'b0;
    logic [DW-1:0] mem_rd_data;
    logic          mem_rd_en, dump_valid, dump_last, halted, done, timeout;
    logic [AW-1:0] mem_addr, dump_addr;
    logic [DW-1:0] dump_data;

    logic [DW-1:0] ram [0:255];
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) mem_rd_data <= ram[mem_addr];

    halt_dump_monitor #(
        .DATA_W(DW), .ADDR_W(AW), .STABLE_CYCLES(16),
        .DUMP_BASE(BASE), .DUMP_COUNT(NWORDS), .WDOG_CYCLES(65536)
    ) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst(inst), .pc(pc),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_last(dump_last), .halted(halted),
        .done(done), .timeout(timeout), .rearm(rearm)
    );

    typedef struct {
        logic          iv;
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
        logic          rearm;
        logic          exp_halted;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rd_en"},   mem_rd_en,  0);
        chk({tag, "_mem_addr"}, mem_addr,  0);
        chk({tag, "_valid"},   dump_valid, 0);
        chk({tag, "_addr"},    dump_addr,  0);
        chk({tag, "_data"},    dump_data,  0);
        chk({tag, "_last"},    dump_last,  0);
        chk({tag, "_halted"},  halted,     0);
        chk({tag, "_done"},    done,       0);
        chk({tag, "_timeout"}, timeout,    0);
    endtask

    task automatic add(input logic iv, input logic [AW-1:0] p, input logic [DW-1:0] i,
                       input logic ra, input logic eh);
        vec_t v;
        v.iv = iv; v.pc = p; v.inst = i; v.rearm = ra; v.exp_halted = eh;
        tbl.push_back(v);
    endtask

    // One initial fetch plus 16 repeats of the same {pc,inst}.
    task automatic run_loop(input logic [AW-1:0] p, input logic [DW-1:0] i, input string tag);
        for (int k = 0; k <= 16; k++) begin
            inst_valid = 1'b1; pc = p; inst = i;
            tick();
            if (k == 15) chk({tag, "_pre_halt"}, halted, 0);
        end
        inst_valid = 1'b0;
        chk({tag, "_halted"}, halted, 1);
        chk({tag, "_rd_en"}, mem_rd_en, 1);
    endtask

    task automatic run_dump(input int stall_word, input int stall_len, input bit rearm_mid,
                            input string tag);
        int rd_n, words, stalled, cyc;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_data;
        rd_n = 0; words = 0; stalled = 0; cyc = 0; h_addr = '0; h_data = '0;
        while (words < NWORDS && cyc < 400) begin
            rearm = 1'b0;
            dump_ready = 1'b1;
            if (mem_rd_en) begin
                chk({tag, "_rd_addr"}, mem_addr, BASE + rd_n);
                rd_n++;
            end
            if (dump_valid) begin
                if (words == stall_word && stalled < stall_len) begin
                    dump_ready = 1'b0;
                    if (stalled == 0) begin
                        h_addr = dump_addr; h_data = dump_data;
                    end else begin
                        chk({tag, "_stall_addr"}, dump_addr, h_addr);
                        chk({tag, "_stall_data"}, dump_data, h_data);
                    end
                    stalled++;
                end else begin
                    chk({tag, "_addr"}, dump_addr, BASE + words);
                    chk({tag, "_data"}, dump_data, ram[BASE + words]);
                    chk({tag, "_last"}, dump_last, (words == NWORDS - 1) ? 1 : 0);
                    if (rearm_mid && words == 2) rearm = 1'b1;
                    words++;
                end
            end
            tick();
            cyc++;
        end
        rearm = 1'b0;
        dump_ready = 1'b0;
        chk({tag, "_in_budget"}, (cyc < 400) ? 1 : 0, 1);
        chk({tag, "_rd_count"}, rd_n, NWORDS);
        if (stall_word >= 0) chk({tag, "_stall_len"}, stalled, stall_len);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_valid_end"}, dump_valid, 0);
        chk({tag, "_rd_en_end"}, mem_rd_en, 0);
        chk({tag, "_halted_end"}, halted, 1);
        chk({tag, "_timeout_end"}, timeout, 0);
    endtask

`ifdef HDM_WATCHDOG_EN
    logic          w_rst_n = 1'b0;
    logic          w_inst_valid = 1'b0;
    logic [DW-1:0] w_inst = '0;
    logic [AW-1:0] w_pc = '0;
    logic          w_rearm = 1'b0;
    logic          w_dump_ready = 1'b1;
    logic [DW-1:0] w_mem_rd_data = '0;
    logic          w_mem_rd_en, w_dump_valid, w_dump_last, w_halted, w_done, w_timeout;
    logic [AW-1:0] w_mem_addr, w_dump_addr;
    logic [DW-1:0] w_dump_data;

    halt_dump_monitor #(
        .DATA_W(DW), .ADDR_W(AW), .STABLE_CYCLES(16),
        .DUMP_BASE(BASE), .DUMP_COUNT(NWORDS), .WDOG_CYCLES(100)
    ) dut_wd (
        .clk(clk), .rst_n(w_rst_n), .inst_valid(w_inst_valid), .inst(w_inst), .pc(w_pc),
        .mem_rd_en(w_mem_rd_en), .mem_addr(w_mem_addr), .mem_rd_data(w_mem_rd_data),
        .dump_valid(w_dump_valid), .dump_ready(w_dump_ready), .dump_addr(w_dump_addr),
        .dump_data(w_dump_data), .dump_last(w_dump_last), .halted(w_halted),
        .done(w_done), .timeout(w_timeout), .rearm(w_rearm)
    );
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        for (int a = 0; a < 256; a++) ram[a] = 32'hA500_0000 + 32'(a * 7);
        ram[0] = 32'd3628800;

        // Near-miss: 1+15 matches, a different inst at the same pc, then 1+15 again.
        for (int k = 0; k < 16; k++) add(1'b1, 8'd30, 32'hDEAD_0030, 1'b0, 1'b0);
        add(1'b1, 8'd30, 32'hDEAD_0031, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) add(1'b1, 8'd30, 32'hDEAD_0030, 1'b0, 1'b0);
        // Distinct fetches, then the terminal loop with an idle gap and a stray rearm.
        for (int p = 0; p < 10; p++) add(1'b1, 8'(p), 32'h0000_0100 + 32'(p), 1'b0, 1'b0);
        for (int k = 0; k <= 16; k++) begin
            if (k == 8) add(1'b0, 8'd10, 32'h0000_000A, 1'b0, 1'b0);
            add(1'b1, 8'd10, 32'h0000_000A, (k == 5) ? 1'b1 : 1'b0, (k == 16) ? 1'b1 : 1'b0);
        end

        #12;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[n]) begin
            inst_valid = tbl[n].iv; pc = tbl[n].pc; inst = tbl[n].inst; rearm = tbl[n].rearm;
            tick();
            chk($sformatf("vec%0d_halted", n), halted, tbl[n].exp_halted);
            chk($sformatf("vec%0d_rd_en", n), mem_rd_en, tbl[n].exp_halted);
        end
        inst_valid = 1'b0;
        rearm = 1'b0;
        chk("first_rd_addr_pre", mem_addr, BASE);

        run_dump(3, 5, 1'b1, "d1");

        // Fetches in DONE are ignored.
        for (int k = 0; k < 20; k++) begin
            inst_valid = 1'b1; pc = 8'd20; inst = 32'h0000_0014;
            tick();
        end
        inst_valid = 1'b0;
        chk("done_hold_done", done, 1);
        chk("done_hold_rd_en", mem_rd_en, 0);

        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        chk("rearm_halted", halted, 0);
        chk("rearm_done", done, 0);
        chk("rearm_valid", dump_valid, 0);

        run_loop(8'd20, 32'h0000_0014, "loop2");
        run_dump(-1, 0, 1'b0, "d2");

        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        run_loop(8'd40, 32'h0000_0028, "loop3");
        dump_ready = 1'b1;
        for (int c = 0; c < 100 && !(dump_valid && dump_addr == 8'd5); c++) tick();
        chk("midrst_reach_w5", (dump_valid && dump_addr == 8'd5) ? 1 : 0, 1);
        #2;
        rst_n = 1'b0;
        dump_ready = 1'b0;
        #1;
        chk_idle("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle("post_rst");

        run_loop(8'd50, 32'h0000_0032, "loop4");
        run_dump(-1, 0, 1'b0, "d3");

`ifdef HDM_WATCHDOG_EN
        begin
            int n;
            tick();
            w_rst_n = 1'b1;
            n = 0;
            while (!w_mem_rd_en && n < 200) begin
                w_inst_valid = 1'b1; w_pc = 8'(n); w_inst = 32'(n);
                tick();
                n++;
            end
            w_inst_valid = 1'b0;
            chk("wd_cycles", n, 100);
            chk("wd_timeout", w_timeout, 1);
            chk("wd_halted", w_halted, 0);
            chk("wd_rd_addr", w_mem_addr, BASE);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
